// File: rtl/traffic_controller.sv
// Intersection phase sequencer. It drives the main, side and walk lights and loads
// the countdown timer on every phase entry. It advances when the timer reports expiry.
//
// state  | meaning
// S_RST  | all red after reset, leaves on the first edge
// S_MG   | main green, side red
// S_MY   | main yellow, side red
// S_WALK | all red, walk lamp on
// S_SG   | main red, side green
// S_SGX  | main red, side green extension
// S_SY   | main red, side yellow
module traffic_controller #(
  parameter logic [3:0] T_BASE = 4'd6,
  parameter logic [3:0] T_EXT  = 4'd3,
  parameter logic [3:0] T_YEL  = 4'd2,
  parameter logic [3:0] T_WALK = 4'd5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       expired,
  input  logic       sensor,
  input  logic       walk_request,
  output logic [3:0] value,
  output logic       start_timer,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk
);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef enum logic [2:0] {
    S_RST,
    S_MG,
    S_MY,
    S_WALK,
    S_SG,
    S_SGX,
    S_SY
  } state_t;

  state_t     state_q, state_d;
  logic       walk_pend, armed;
  logic       accept, take;
  logic [3:0] value_d;
  logic [2:0] main_d, side_d;
  logic       walk_d;

  assign accept = expired & armed;

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    case (state_q)
      S_RST: begin
        take    = 1'b1;
        state_d = S_MG;
      end
      S_MG: if (accept) begin
        take    = 1'b1;
        state_d = (sensor || walk_pend) ? S_MY : S_MG;
      end
      S_MY: if (accept) begin
        take    = 1'b1;
        state_d = walk_pend ? S_WALK : S_SG;
      end
      S_WALK: if (accept) begin
        take    = 1'b1;
        state_d = sensor ? S_SG : S_MG;
      end
      S_SG: if (accept) begin
        take    = 1'b1;
        state_d = sensor ? S_SGX : S_SY;
      end
      S_SGX: if (accept) begin
        take    = 1'b1;
        state_d = S_SY;
      end
      S_SY: if (accept) begin
        take    = 1'b1;
        state_d = S_MG;
      end
      default: begin
        take    = 1'b1;
        state_d = S_MG;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the entry edge
  always_comb begin
    value_d = T_BASE;
    main_d  = RED;
    side_d  = RED;
    walk_d  = 1'b0;
    case (state_d)
      S_MG: begin
        main_d  = GRN;
        value_d = T_BASE;
      end
      S_MY: begin
        main_d  = YEL;
        value_d = T_YEL;
      end
      S_WALK: begin
        walk_d  = 1'b1;
        value_d = T_WALK;
      end
      S_SG: begin
        side_d  = GRN;
        value_d = T_BASE;
      end
      S_SGX: begin
        side_d  = GRN;
        value_d = T_EXT;
      end
      S_SY: begin
        side_d  = YEL;
        value_d = T_YEL;
      end
      default: begin
        value_d = T_BASE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RST;
      walk_pend   <= 1'b0;
      armed       <= 1'b0;
      start_timer <= 1'b0;
      value       <= T_BASE;
      main_light  <= RED;
      side_light  <= RED;
      walk        <= 1'b0;
    end else begin
      state_q     <= state_d;
      // a request in the same cycle as the walk entry keeps the latch set
      walk_pend   <= walk_request | (walk_pend & ~(take && (state_d == S_WALK)));
      armed       <= ~take;
      start_timer <= take;
      value       <= value_d;
      main_light  <= main_d;
      side_light  <= side_d;
      walk        <= walk_d;
    end
  end

endmodule

// File: tb/tb_traffic_controller.sv
// Bench for traffic_controller: directed scenarios followed by random traffic.
// All results are checked against a phase-level reference model.
module tb_traffic_controller;

  localparam int TB_BASE = 6;
  localparam int TB_EXT  = 3;
  localparam int TB_YEL  = 2;
  localparam int TB_WALK = 5;

  localparam int P_RST  = 0;
  localparam int P_MG   = 1;
  localparam int P_MY   = 2;
  localparam int P_WALK = 3;
  localparam int P_SG   = 4;
  localparam int P_SGX  = 5;
  localparam int P_SY   = 6;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       expired = 1'b0;
  logic       sensor = 1'b0;
  logic       walk_request = 1'b0;
  logic [3:0] value;
  logic       start_timer;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;

  int n_cmp = 0;
  int n_bad = 0;

  int ph  = P_RST;
  int age = 0;
  bit pend = 1'b0;

  traffic_controller dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .expired      (expired),
    .sensor       (sensor),
    .walk_request (walk_request),
    .value        (value),
    .start_timer  (start_timer),
    .main_light   (main_light),
    .side_light   (side_light),
    .walk         (walk)
  );

  always #5 clock = ~clock;

  function automatic int dur(input int p);
    case (p)
      P_MY, P_SY: return TB_YEL;
      P_WALK:     return TB_WALK;
      P_SGX:      return TB_EXT;
      default:    return TB_BASE;
    endcase
  endfunction

  function automatic logic [2:0] main_exp(input int p);
    case (p)
      P_MG:    return 3'b001;
      P_MY:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] side_exp(input int p);
    case (p)
      P_SG, P_SGX: return 3'b001;
      P_SY:        return 3'b010;
      default:     return 3'b100;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (phase %0d, t=%0t)", tag, obs, exp, ph, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("main_light", 16'(main_light), 16'(main_exp(ph)));
    check_val("side_light", 16'(side_light), 16'(side_exp(ph)));
    check_val("walk", 16'(walk), 16'(ph == P_WALK));
    check_val("start_timer", 16'(start_timer), 16'((ph != P_RST) && (age == 0)));
    check_val("value", 16'(value), 16'(dur(ph)));
  endtask

  // One clock edge of the reference: expiry is honoured only once a phase is a cycle old
  task automatic model_step();
    int nxt;
    bit go;
    if (!reset_n) begin
      ph = P_RST; pend = 1'b0; age = 0;
      return;
    end
    nxt = ph;
    go  = 1'b0;
    if (ph == P_RST) begin
      nxt = P_MG; go = 1'b1;
    end else if (expired && age >= 1) begin
      go = 1'b1;
      case (ph)
        P_MG:    nxt = (sensor || pend) ? P_MY : P_MG;
        P_MY:    nxt = pend ? P_WALK : P_SG;
        P_WALK:  nxt = sensor ? P_SG : P_MG;
        P_SG:    nxt = sensor ? P_SGX : P_SY;
        P_SGX:   nxt = P_SY;
        default: nxt = P_MG;
      endcase
    end
    if (walk_request) pend = 1'b1;
    else if (go && nxt == P_WALK) pend = 1'b0;
    if (go) begin
      ph = nxt; age = 0;
    end else if (age < 1000) begin
      age++;
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit s, input bit w);
    @(negedge clock);
    check_outputs();
    reset_n      = r;
    expired      = e;
    sensor       = s;
    walk_request = w;
    model_step();
  endtask

  task automatic phase_end(input bit s, input bit w);
    cycle(1'b1, 1'b0, s, 1'b0);
    cycle(1'b1, 1'b1, s, w);
  endtask

  initial begin
    // held in reset, then release with an expiry in the first loaded cycle
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    // side cycle with extension
    phase_end(1'b1, 1'b0);
    phase_end(1'b0, 1'b0);
    phase_end(1'b1, 1'b0);
    phase_end(1'b0, 1'b0);
    phase_end(1'b0, 1'b0);
    // pedestrian with a second request on the walk entry edge
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    phase_end(1'b0, 1'b0);
    phase_end(1'b0, 1'b1);
    phase_end(1'b0, 1'b0);
    phase_end(1'b0, 1'b0);
    phase_end(1'b0, 1'b0);
    phase_end(1'b0, 1'b0);
    // back-to-back expiry pulses
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    // reach the extension phase and reset between edges
    for (int i = 0; i < 20 && ph != P_SGX; i++) phase_end(1'b1, 1'b0);
    check_val("reached_sgx", 16'(ph), 16'(P_SGX));
    @(negedge clock);
    check_outputs();
    #2 reset_n = 1'b0;
    expired = 1'b0; sensor = 1'b0; walk_request = 1'b0;
    #1;
    check_val("async_main_red", 16'(main_light), 16'h4);
    check_val("async_side_red", 16'(side_light), 16'h4);
    model_step();
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    // random traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 599) != 0), ($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    check_outputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
